// File: rtl/uart_cmd_rx.sv
// Serial command receiver: 8N1 deserialiser feeding a [0xA5, CMD, CHK] frame parser.
// The 2-bit opcode goes out on a valid/ready handshake; framing, checksum and overrun errors are 1-cycle pulses.
`timescale 1ns/1ps
module uart_cmd_rx #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115_200,
  parameter int TO_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic [1:0] opcode,
  output logic       cmd_valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       chk_err,
  output logic       overrun,
  output logic [1:0] dbg_bit_state,
  output logic [1:0] dbg_frame_state
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid && ready.
  // Once cmd_valid is raised, opcode is held stable until that transfer.

  localparam int DIV      = CLK_HZ / (BAUD * 16);
  localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_TICKS = TO_BITS * 16;
  localparam int TW       = $clog2(TO_TICKS + 1);
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
  typedef enum logic [1:0] {F_HDR, F_CMD, F_CHK} frame_state_t;

  bit_state_t   b_state, b_next;
  frame_state_t f_state, f_next;

  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    fill;
  logic          armed;
  logic          fall;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    samp;
  logic          maj;
  logic [7:0]    shreg;
  logic [7:0]    cmd_byte;
  logic [TW-1:0] to_cnt;

  logic start_go, start_bad, byte_done, stop_bad;
  logic timeout, frame_good, frame_bad;
  logic accept;

  // Synchroniser; armed stays low until a real 1 has been seen after reset,
  // so a line held low through reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= RxD;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      fill    <= {fill[0], 1'b1};
      armed   <= armed | (fill[1] & rx_sync);
    end
  end

  assign fall = armed & rx_prev & ~rx_sync;
  assign tick = (div_cnt == DW'(DIV - 1));
  assign maj  = (samp[0] & samp[1]) | (samp[0] & rx_sync) | (samp[1] & rx_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      samp     <= '0;
      shreg    <= '0;
    end else begin
      if (start_go || tick) div_cnt <= '0;
      else                  div_cnt <= div_cnt + 1'b1;

      if (start_go)  tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 1'b1;

      if (start_go)
        bit_cnt <= '0;
      else if (b_state == B_DATA && tick && tick_cnt == 4'd15)
        bit_cnt <= bit_cnt + 1'b1;

      if (tick && tick_cnt == 4'd7) samp[0] <= rx_sync;
      if (tick && tick_cnt == 4'd8) samp[1] <= rx_sync;

      if (b_state == B_DATA && tick && tick_cnt == 4'd9)
        shreg <= {maj, shreg[7:1]};
    end
  end

  // Bit FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b_state <= B_IDLE;
    else        b_state <= b_next;
  end

  always_comb begin
    b_next = b_state;
    case (b_state)
      B_IDLE:  if (fall) b_next = B_START;
      B_START: begin
        if (tick && tick_cnt == 4'd7 && rx_sync) b_next = B_IDLE;
        else if (tick && tick_cnt == 4'd15)      b_next = B_DATA;
      end
      B_DATA:  if (tick && tick_cnt == 4'd15 && bit_cnt == 3'd7) b_next = B_STOP;
      B_STOP:  if (tick && tick_cnt == 4'd9) b_next = B_IDLE;
      default: b_next = B_IDLE;
    endcase
  end

  always_comb begin
    start_go  = 1'b0;
    start_bad = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (b_state)
      B_IDLE:  start_go  = fall;
      B_START: start_bad = tick && tick_cnt == 4'd7 && rx_sync;
      B_STOP: begin
        byte_done = tick && tick_cnt == 4'd9 && maj;
        stop_bad  = tick && tick_cnt == 4'd9 && !maj;
      end
      default: ;
    endcase
  end

  // Frame FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_state <= F_HDR;
    else        f_state <= f_next;
  end

  always_comb begin
    f_next = f_state;
    case (f_state)
      F_HDR: if (byte_done && shreg == HDR_BYTE) f_next = F_CMD;
      F_CMD: begin
        if (byte_done)                f_next = F_CHK;
        else if (stop_bad || timeout) f_next = F_HDR;
      end
      F_CHK: if (byte_done || stop_bad || timeout) f_next = F_HDR;
      default: f_next = F_HDR;
    endcase
  end

  always_comb begin
    timeout    = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    if (f_state != F_HDR)
      timeout = tick && (to_cnt == TW'(TO_TICKS - 1));
    if (f_state == F_CHK && byte_done) begin
      if (shreg == (HDR_BYTE ^ cmd_byte) && cmd_byte[7:2] == 6'd0) frame_good = 1'b1;
      else                                                        frame_bad  = 1'b1;
    end
  end

  // Inter-byte timeout counts ticks since the last delivered byte of a partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_byte <= '0;
      to_cnt   <= '0;
    end else begin
      if (f_state == F_CMD && byte_done) cmd_byte <= shreg;
      if (f_state == F_HDR || byte_done) to_cnt <= '0;
      else if (tick)                     to_cnt <= to_cnt + 1'b1;
    end
  end

  assign accept = cmd_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode    <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      chk_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= start_bad | stop_bad;
      chk_err   <= frame_bad;
      overrun   <= frame_good & cmd_valid & ~accept;
      // A completion coinciding with acceptance reloads instead of clearing.
      if (frame_good && (!cmd_valid || accept)) begin
        cmd_valid <= 1'b1;
        opcode    <= cmd_byte[1:0];
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign dbg_bit_state   = b_state;
  assign dbg_frame_state = f_state;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at DIV=1 (16 clk per bit, 10 ns clock).
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int BIT_NS = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [1:0] opcode;
  logic       cmd_valid, frame_err, chk_err, overrun;
  logic [1:0] dbg_bit_state, dbg_frame_state;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0, ce_cnt = 0, ov_cnt = 0;
  int fe0, ce0, ov0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .TO_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .RxD(rxd),
    .opcode(opcode), .cmd_valid(cmd_valid), .ready(ready),
    .frame_err(frame_err), .chk_err(chk_err), .overrun(overrun),
    .dbg_bit_state(dbg_bit_state), .dbg_frame_state(dbg_frame_state)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (chk_err)   ce_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bit_ns, input logic stop_v, input int gap_bits);
    @(negedge clk);
    rxd = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns);
    end
    rxd = stop_v;
    #(bit_ns);
    rxd = 1'b1;
    #(gap_bits * bit_ns);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int bit_ns);
    send_byte(b0, bit_ns, 1'b1, 2);
    send_byte(b1, bit_ns, 1'b1, 2);
    send_byte(b2, bit_ns, 1'b1, 2);
  endtask

  task automatic snap();
    fe0 = fe_cnt; ce0 = ce_cnt; ov0 = ov_cnt;
  endtask

  task automatic check_pending(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, cmd_valid, 1);
    if (exp_q.size() == 0) check({tag, "_queue"}, 0, 1);
    else                   check({tag, "_opcode"}, opcode, exp_q[0]);
  endtask

  task automatic accept_cmd(input string tag);
    logic [1:0] exp_op;
    exp_op = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({tag, "_acc_valid"}, cmd_valid, 0);
    check({tag, "_acc_opcode"}, opcode, exp_op);
  endtask

  initial begin
    // reset state
    repeat (4) @(negedge clk);
    check("rst_opcode", opcode, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_pulses", {frame_err, chk_err, overrun}, 0);
    check("rst_bit_state", dbg_bit_state, 0);
    check("rst_frame_state", dbg_frame_state, 0);
    rst_n = 1'b1;
    #(2 * BIT_NS);

    // 1: good frame held with ready low, then accepted
    snap();
    exp_q.push_back(2'd2);
    send_frame(8'hA5, 8'h02, 8'hA7, BIT_NS);
    check_pending("t1");
    repeat (100) @(negedge clk);
    check_pending("t1_hold");
    check("t1_errs", fe_cnt + ce_cnt + ov_cnt - fe0 - ce0 - ov0, 0);
    accept_cmd("t1");

    // 2: bad checksum, then good frame
    snap();
    send_frame(8'hA5, 8'h01, 8'hA5, BIT_NS);
    @(negedge clk);
    check("t2_chk_err", ce_cnt - ce0, 1);
    check("t2_no_cmd", cmd_valid, 0);
    exp_q.push_back(2'd3);
    send_frame(8'hA5, 8'h03, 8'hA6, BIT_NS);
    check_pending("t2");
    check("t2_chk_err_once", ce_cnt - ce0, 1);
    accept_cmd("t2");

    // 3: stop bit low, then good frame with opcode 0
    snap();
    send_byte(8'h55, BIT_NS, 1'b0, 2);
    @(negedge clk);
    check("t3_frame_err", fe_cnt - fe0, 1);
    exp_q.push_back(2'd0);
    send_frame(8'hA5, 8'h00, 8'hA5, BIT_NS);
    check_pending("t3");
    check("t3_frame_err_once", fe_cnt - fe0, 1);
    accept_cmd("t3");

    // 4: second frame while first pending -> overrun, first kept
    snap();
    exp_q.push_back(2'd1);
    send_frame(8'hA5, 8'h01, 8'hA4, BIT_NS);
    send_frame(8'hA5, 8'h02, 8'hA7, BIT_NS);
    check_pending("t4");
    check("t4_overrun", ov_cnt - ov0, 1);
    accept_cmd("t4");

    // 5: partial frame times out, stray bytes ignored, then a clean frame
    snap();
    send_byte(8'hA5, BIT_NS, 1'b1, 2);
    send_byte(8'h01, BIT_NS, 1'b1, 2);
    #(32 * BIT_NS);
    send_byte(8'h01, BIT_NS, 1'b1, 2);
    send_byte(8'hA4, BIT_NS, 1'b1, 2);
    @(negedge clk);
    check("t5_no_cmd", cmd_valid, 0);
    check("t5_no_err", fe_cnt + ce_cnt + ov_cnt - fe0 - ce0 - ov0, 0);
    exp_q.push_back(2'd1);
    send_frame(8'hA5, 8'h01, 8'hA4, BIT_NS);
    check_pending("t5");
    accept_cmd("t5");

    // 6: reset mid-data of the CHK byte, line low across release
    snap();
    send_byte(8'hA5, BIT_NS, 1'b1, 2);
    send_byte(8'h02, BIT_NS, 1'b1, 2);
    @(negedge clk);
    rxd = 1'b0;
    #(BIT_NS);
    rxd = 1'b1;
    #(3 * BIT_NS);
    rxd = 1'b0;
    #(BIT_NS / 2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_opcode", opcode, 0);
    check("t6_rst_valid", cmd_valid, 0);
    check("t6_rst_bit_state", dbg_bit_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #(12 * BIT_NS);
    rxd = 1'b1;
    #(3 * BIT_NS);
    check("t6_no_spurious", fe_cnt - fe0, 0);
    check("t6_no_cmd", cmd_valid, 0);
    exp_q.push_back(2'd2);
    send_frame(8'hA5, 8'h02, 8'hA7, BIT_NS);
    check_pending("t6");
    check("t6_clean", fe_cnt + ce_cnt + ov_cnt - fe0 - ce0 - ov0, 0);
    accept_cmd("t6");

    // 7: sender about 3% slow, then about 3% fast
    snap();
    exp_q.push_back(2'd3);
    send_frame(8'hA5, 8'h03, 8'hA6, 165);
    check_pending("t7_slow");
    accept_cmd("t7_slow");
    exp_q.push_back(2'd3);
    send_frame(8'hA5, 8'h03, 8'hA6, 155);
    check_pending("t7_fast");
    accept_cmd("t7_fast");
    check("t7_no_err", fe_cnt + ce_cnt + ov_cnt - fe0 - ce0 - ov0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
